// File: rtl/ahb_subordinate_sram.sv
// ahb_subordinate_sram
//   AHB subordinate that terminates manager transfers into an internal
//   flop-based word memory. Zero or programmable wait states per OKAY data
//   phase, two-cycle ERROR response for out-of-range / misaligned /
//   oversized transfers.
//
//   Optional build macro: AHB_SUBORDINATE_RETRY_EN
//     When defined, every RETRY_PERIOD-th accepted non-error NONSEQ gets a
//     two-cycle RETRY response instead of being performed.
//
// Ports
//   i_hclk, i_hreset_n      clock, async active-low reset
//   i_hsel                  subordinate select
//   i_haddr, i_htrans       address-phase address / transfer type
//   i_hwrite, i_hsize       direction, log2 transfer bytes
//   i_hburst                burst type (not checked)
//   i_hwdata                write data (data phase)
//   i_hready                bus HREADY
//   o_hreadyout             data-phase ready
//   o_hresp                 OKAY=0, ERROR=1, RETRY=2
//   o_hrdata                read data
module ahb_subordinate_sram #(
    parameter int DATA_WDT     = 32,
    parameter int MEM_AW       = 8,
    parameter int WAIT_STATES  = 0,
    parameter int RETRY_PERIOD = 4
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic                o_hreadyout,
    output logic [1:0]          o_hresp,
    output logic [DATA_WDT-1:0] o_hrdata
);
    localparam int BPW   = DATA_WDT / 8;
    localparam int BSZ   = $clog2(BPW);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int AW    = MEM_AW + BSZ;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ERR1, S_ERR2
`ifdef AHB_SUBORDINATE_RETRY_EN
        , S_RTY1, S_RTY2
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic                pend_q;      // an OKAY transfer owns the current data phase
    logic                wr_q;
    logic [2:0]          size_q;
    logic [AW-1:0]       addr_q;
    logic [DATA_WDT-1:0] mem_q [DEPTH];

    logic                rdy, acc, err, rty_hit, we;
    logic [BPW-1:0]      be;
    logic [MEM_AW-1:0]   widx;

    // Address-phase decode; only sampled while this subordinate is ready.
    assign acc = i_hsel & i_hready & i_htrans[1] & rdy;
    assign err = ({1'b0, i_haddr} >= 33'(DEPTH * BPW))
               | ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0)
               | (i_hsize > 3'(BSZ));

`ifdef AHB_SUBORDINATE_RETRY_EN
    logic [15:0] rcnt_q, rcnt_d;

    always_comb begin
        rcnt_d  = rcnt_q;
        rty_hit = 1'b0;
        if (acc && !err && i_htrans == 2'b10) begin
            rcnt_d  = rcnt_q + 16'd1;
            rty_hit = (rcnt_d % 16'(RETRY_PERIOD)) == 16'd0;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n)
        if (!i_hreset_n) rcnt_q <= '0;
        else             rcnt_q <= rcnt_d;
`else
    assign rty_hit = 1'b0;
`endif

    // Output decode from state only.
    always_comb begin
        rdy     = 1'b1;
        o_hresp = 2'b00;
        case (state_q)
            S_WAIT: rdy = 1'b0;
            S_ERR1: begin rdy = 1'b0; o_hresp = 2'b01; end
            S_ERR2: o_hresp = 2'b01;
`ifdef AHB_SUBORDINATE_RETRY_EN
            S_RTY1: begin rdy = 1'b0; o_hresp = 2'b10; end
            S_RTY2: o_hresp = 2'b10;
`endif
            default: ;
        endcase
    end
    assign o_hreadyout = rdy;

    // Next state. Every ready state (IDLE, ERR2, RTY2) can take a new
    // address phase, so they share one evaluation.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_WAIT: begin
                wcnt_d = wcnt_q - 3'd1;
                if (wcnt_q <= 3'd1) state_d = S_IDLE;
            end
            S_ERR1: state_d = S_ERR2;
`ifdef AHB_SUBORDINATE_RETRY_EN
            S_RTY1: state_d = S_RTY2;
`endif
            default: begin
                state_d = S_IDLE;
                if (acc) begin
                    if (err) state_d = S_ERR1;
`ifdef AHB_SUBORDINATE_RETRY_EN
                    else if (rty_hit) state_d = S_RTY1;
`endif
                    else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 3'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n)
        if (!i_hreset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (rdy) pend_q <= acc & ~err & ~rty_hit;
            if (acc) begin
                wr_q   <= i_hwrite;
                size_q <= i_hsize;
                addr_q <= i_haddr[AW-1:0];
            end
        end

    // Commit happens at the end of the ready data phase of an OKAY write.
    assign we   = rdy & pend_q & wr_q;
    assign widx = addr_q[AW-1:BSZ];

    always_comb begin
        be = '0;
        for (int b = 0; b < BPW; b++)
            be[b] = (b >= int'(addr_q[BSZ-1:0])) &&
                    (b < int'(addr_q[BSZ-1:0]) + (1 << size_q));
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n)
        if (!i_hreset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < BPW; b++)
                if (be[b]) mem_q[widx][8*b +: 8] <= i_hwdata[8*b +: 8];
        end

    // Read data only while a read owns the data phase (including its waits).
    assign o_hrdata = (pend_q && !wr_q && (state_q == S_IDLE || state_q == S_WAIT))
                    ? mem_q[widx] : '0;
endmodule

// File: doc/ahb_subordinate_sram.md
Name: ahb_subordinate_sram

Overview:
AHB subordinate (responder) that terminates manager transfers into an internal flop-based word memory.
- Decodes address/control phases and supplies HREADYOUT/HRESP/HRDATA.
- Applies programmable wait states and signals the two-cycle ERROR response.
- Serves as the bus-side counterpart for system integration and as the standard target for manager regression benches.

Parameters:
DATA_WDT, 32, data bus width in bits; 32 or 64.
MEM_AW, 8, log2 of memory depth in words; byte range = 2^MEM_AW * DATA_WDT/8.
WAIT_STATES, 0, wait cycles inserted per OKAY data phase; 0..7.
RETRY_PERIOD, 4, RETRY injected on every Nth accepted NONSEQ; used only with optional feature.

Ports:
i_hclk  in  1  clock.
i_hreset_n  in  1  reset, async assert, active-low.
i_hsel  in  1  subordinate select.
i_haddr  in  32  address.
i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
i_hwrite  in  1  1=write.
i_hsize  in  3  transfer size, log2 bytes.
i_hburst  in  3  burst type; informational, not checked.
i_hwdata  in  DATA_WDT  write data, data phase.
i_hready  in  1  bus HREADY (end of the previous data phase).
o_hreadyout  out  1  this subordinate's data-phase ready.
o_hresp  out  2  OKAY=0, ERROR=1, RETRY=2.
o_hrdata  out  DATA_WDT  read data, valid when o_hreadyout=1 and OKAY.

Behaviour:
- Reset values:
  - o_hreadyout=1, o_hresp=OKAY, o_hrdata=0.
  - All memory words 0, FSM=IDLE, wait counter 0, retry counter 0.
- Address-phase accept (acc): i_hsel & i_hready & i_htrans[1].
  - On acc, register addr, size, write and a cycle-later error flag.
  - BUSY, IDLE, or an unselected cycle with i_hready=1: next data phase is OKAY, zero wait, no memory access.
- Error flag set when any of the following holds:
  - i_haddr >= byte range.
  - Misaligned: i_haddr & ((1<<i_hsize)-1) != 0.
  - (8<<i_hsize) > DATA_WDT.
- FSM states: IDLE, WAIT, ERR1, ERR2, RTY1, RTY2.
  - IDLE: o_hreadyout=1, OKAY.
    - acc & err -> ERR1.
    - acc & ~err & WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
    - Otherwise stay IDLE; a zero-wait transfer completes in the next cycle.
  - WAIT: o_hreadyout=0, OKAY; counter decrements; at counter==1 -> IDLE, so the data phase ends on the following cycle.
  - ERR1: o_hreadyout=0, ERROR -> ERR2.
  - ERR2: o_hreadyout=1, ERROR.
    - Next state re-evaluated exactly as from IDLE, so a new address phase is accepted in the same cycle.
    - Otherwise -> IDLE.
- Write commit:
  - Occurs on the cycle where the data phase completes with OKAY (o_hreadyout=1, prior accept was a write, no error).
  - Byte lanes from the registered addr low bits and size, little-endian; other lanes unchanged.
  - Error or RETRY data phases never modify memory.
- Read data:
  - o_hrdata = mem[registered word addr], combinational from the flop array during the data phase, full word.
  - Forced 0 in ERROR/RETRY states and in IDLE with no pending read.
  - Read immediately following a write to the same word returns the new data; the write commits before the read's data phase.
- Pipelining: the data-phase end of transfer N and the address accept of N+1 occur in the same cycle. Back-to-back zero-wait transfers sustain 1 transfer/cycle.
- While o_hreadyout=0, the address inputs are ignored (i_hready is low bus-wide).
- Reset mid-transfer: immediate return to the reset values; the pending write is discarded.

Optional Feature:
- Macro: AHB_SUBORDINATE_RETRY_EN.
- Defined:
  - A 16-bit counter increments on each accepted non-error NONSEQ.
  - When the incremented value mod RETRY_PERIOD == 0, the FSM goes to RTY1 instead of IDLE/WAIT.
  - RTY1: o_hreadyout=0, RETRY. RTY2: o_hreadyout=1, RETRY, transitions as in ERR2.
  - No memory update. The manager's re-issued transfer counts as a new NONSEQ.
- Undefined: RTY states, the counter and RETRY_PERIOD logic are absent; o_hresp is never RETRY.

Test Plan:
1. WAIT_STATES=0: write NONSEQ W32 0x10 data 0xDEADBEEF, then read NONSEQ 0x10 back-to-back -> o_hreadyout stays 1, o_hresp=OKAY, o_hrdata=0xDEADBEEF in the read's data phase.
2. Write W8 0x13 data 0xAA000000 over word 0x11223344 -> word reads 0xAA223344.
3. WAIT_STATES=3: read 0x0 -> o_hreadyout low for exactly 3 cycles, then 1 with o_hrdata=0.
4. Read 0x400 (MEM_AW=8, range 0x400) -> ERROR with o_hreadyout 0 then 1. Repeat with W32 at 0x2 -> same. A following OKAY transfer is accepted in ERR2; memory is unchanged.
5. INCR4 SEQ burst 0x20..0x2C with a BUSY inserted after beat 2 -> BUSY data phase OKAY zero-wait, all 4 words written.
6. With AHB_SUBORDINATE_RETRY_EN, RETRY_PERIOD=4: 4 single NONSEQ writes -> 4th gets RETRY (0 then 1), its word unchanged. Assert i_hreset_n low during WAIT -> o_hreadyout=1, OKAY immediately.
